// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the FPGC interrupt controller: register map,
// state encoding, STATUS field layout and default sizing.
package irq_ctrl_pkg;

  localparam int unsigned NUM_SRC_DEF = 8;
  localparam int unsigned ID_W_DEF    = 3;
  localparam int unsigned REG_W       = 32;

  // Register window offsets
  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  // STATUS field positions
  localparam int unsigned STATUS_STATE_LSB = 30;
  localparam int unsigned STATUS_ANY_BIT   = 8;
  localparam int unsigned STATUS_ID_W      = 8;

  // Assemble the read-only STATUS word; unused bits read 0
  function automatic logic [REG_W-1:0] pack_status(
    input logic [1:0]             st,
    input logic                   any_pending,
    input logic [STATUS_ID_W-1:0] id
  );
    logic [REG_W-1:0] s;
    s = '0;
    s[STATUS_STATE_LSB +: 2]   = st;
    s[STATUS_ANY_BIT]          = any_pending;
    s[STATUS_ID_W-1:0]         = id;
    return s;
  endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Combinational lowest-index-first priority encoder (bit 0 wins).
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned ID_W    = ID_W_DEF
) (
  input  logic [NUM_SRC-1:0] req_in,
  output logic [ID_W-1:0]    id_c,
  output logic               valid_c
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    id_c    = '0;
    valid_c = 1'b0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        id_c    = ID_W'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Parametrised interrupt controller for the FPGC CPU.
// Latches edge/level events per source, masks them, picks the lowest pending
// index and hands it to the CPU over an ack/EOI handshake. Register window:
// PENDING (W1C), MASK, EDGE_SEL, STATUS (read-only), 1-cycle read latency.
// Build option IRQ_CTRL_SYNC_EN: add a 2-flop synchroniser on every src_in bit.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned        NUM_SRC  = NUM_SRC_DEF,
  parameter int unsigned        ID_W     = ID_W_DEF,
  parameter logic [NUM_SRC-1:0] MASK_RST = '1,
  parameter logic [NUM_SRC-1:0] EDGE_RST = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  input  logic [1:0]         reg_addr,
  input  logic               reg_we,
  input  logic [REG_W-1:0]   reg_d,
  output logic [REG_W-1:0]   reg_q
);

  logic [NUM_SRC-1:0] src_cur;

  logic [1:0]         state_q,   state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q,    mask_d;
  logic [NUM_SRC-1:0] edge_q,    edge_d;
  logic [NUM_SRC-1:0] prev_q,    prev_d;
  logic [ID_W-1:0]    id_q,      id_d;
  logic               irq_req_q, irq_req_d;
  logic [REG_W-1:0]   rdata_q,   rdata_d;

  logic [ID_W-1:0]    enc_id;
  logic               enc_valid;
  logic [NUM_SRC-1:0] id_oh;
  logic               unused_reg_d;

  // Write data above NUM_SRC is deliberately dropped
  assign unused_reg_d = ^reg_d;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync1_d;
  logic [NUM_SRC-1:0] sync2_q, sync2_d;

  // Two-stage synchroniser feeding the event logic
  always_comb begin
    sync1_d = src_in;
    sync2_d = sync1_q;
  end

  // Synchroniser flops, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src_cur = sync2_q;
`else
  assign src_cur = src_in;
`endif

  // Pick the highest-priority enabled pending source
  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req_in  (pending_q & mask_q),
    .id_c    (enc_id),
    .valid_c (enc_valid)
  );

  // Next-state, pending update, register writes and read mux
  always_comb begin
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_edge;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] to_edge;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] edge_evt;

    state_d   = state_q;
    id_d      = id_q;
    mask_d    = mask_q;
    edge_d    = edge_q;
    prev_d    = src_cur;
    pending_d = pending_q;
    rdata_d   = '0;
    ack_clr   = '0;
    id_oh     = NUM_SRC'(1) << id_q;

    wr_pend = reg_we && (reg_addr == REG_PENDING);
    wr_mask = reg_we && (reg_addr == REG_MASK);
    wr_edge = reg_we && (reg_addr == REG_EDGE);

    w1c     = wr_pend ? reg_d[NUM_SRC-1:0] : '0;
    to_edge = wr_edge ? (reg_d[NUM_SRC-1:0] & ~edge_q) : '0;

    if (wr_mask) mask_d = reg_d[NUM_SRC-1:0];
    if (wr_edge) edge_d = reg_d[NUM_SRC-1:0];

    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_REQ;
          id_d    = enc_id;
        end
      end
      ST_REQ: begin
        // The CPU has already seen the request, so an ack beats a mask drop
        if (irq_ack) begin
          state_d = ST_SERVE;
          ack_clr = id_oh;
        end else if (~|(mask_q & id_oh)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (irq_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Edge bits: clears first, a fresh edge wins. Level bits mirror the source.
    edge_evt  = src_cur & ~prev_q & edge_q;
    pending_d = (edge_q & ((pending_q & ~(w1c | ack_clr)) | edge_evt))
              | (~edge_q & src_cur);
    pending_d = pending_d & ~to_edge;

    irq_req_d = (state_d == ST_REQ);

    case (reg_addr)
      REG_PENDING: rdata_d = REG_W'(pending_q);
      REG_MASK:    rdata_d = REG_W'(mask_q);
      REG_EDGE:    rdata_d = REG_W'(edge_q);
      REG_STATUS:  rdata_d = pack_status(state_q, |pending_q, STATUS_ID_W'(id_q));
      default:     rdata_d = '0;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      edge_q    <= EDGE_RST;
      prev_q    <= '1;
      id_q      <= '0;
      irq_req_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      prev_q    <= prev_d;
      id_q      <= id_d;
      irq_req_q <= irq_req_d;
      rdata_q   <= rdata_d;
    end
  end

  assign irq_req = irq_req_q;
  assign irq_id  = id_q;
  assign reg_q   = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed vector table, hand-written
// corner sequences and a randomized phase against a behavioural model.
module tb_irq_controller;

  localparam int NS = 8;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic          clk;
  logic          reset;
  logic [NS-1:0] src_in;
  logic          irq_req;
  logic [2:0]    irq_id;
  logic          irq_ack;
  logic          irq_eoi;
  logic [1:0]    reg_addr;
  logic          reg_we;
  logic [31:0]   reg_d;
  logic [31:0]   reg_q;

  int total = 0;
  int bad   = 0;

  irq_controller #(
    .NUM_SRC  (NS),
    .ID_W     (3),
    .MASK_RST (8'hFF),
    .EDGE_RST (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .src_in   (src_in),
    .irq_req  (irq_req),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .irq_eoi  (irq_eoi),
    .reg_addr (reg_addr),
    .reg_we   (reg_we),
    .reg_d    (reg_d),
    .reg_q    (reg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model state (0 idle, 1 requesting, 2 in service)
  bit [7:0]  m_pend, m_mask, m_edge, m_prev;
  int        m_state, m_id;
  bit        m_req;
  bit [31:0] m_rq;
  bit [7:0]  m_syncq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: predict from the present inputs, clock, then compare
  task automatic tick();
    bit [7:0]  n_pend, n_mask, n_edge, n_prev, cur, wr;
    int        n_state, n_id;
    bit [31:0] n_rq;
    bit        ack_taken, p;
    if (reset) begin
      n_pend = 0; n_mask = 8'hFF; n_edge = 8'hFF; n_prev = 8'hFF;
      n_state = 0; n_id = 0; n_rq = 0;
      m_syncq = {};
      for (int k = 0; k < SL; k++) m_syncq.push_back(8'h00);
    end else begin
      if (SL == 0) cur = src_in;
      else begin
        cur = m_syncq.pop_front();
        m_syncq.push_back(src_in);
      end
      wr = reg_d[7:0];
      case (reg_addr)
        2'd0:    n_rq = {24'h0, m_pend};
        2'd1:    n_rq = {24'h0, m_mask};
        2'd2:    n_rq = {24'h0, m_edge};
        default: n_rq = (32'(m_state) << 30) | ((m_pend != 0) ? 32'h100 : 32'h0) | 32'(m_id);
      endcase
      n_state = m_state; n_id = m_id; ack_taken = 0;
      if (m_state == 0) begin
        for (int i = 0; i < NS; i++)
          if (m_pend[i] && m_mask[i]) begin n_state = 1; n_id = i; break; end
      end else if (m_state == 1) begin
        if (irq_ack) begin n_state = 2; ack_taken = 1; end
        else if (!m_mask[m_id]) n_state = 0;
      end else if (irq_eoi) begin
        n_state = 0;
      end
      for (int i = 0; i < NS; i++) begin
        if (m_edge[i]) begin
          p = m_pend[i];
          if (reg_we && reg_addr == 2'd0 && wr[i]) p = 0;
          if (ack_taken && i == m_id) p = 0;
          if (cur[i] && !m_prev[i]) p = 1;
        end else begin
          p = cur[i];
          if (reg_we && reg_addr == 2'd2 && wr[i]) p = 0;
        end
        n_pend[i] = p;
      end
      n_prev = cur;
      n_mask = (reg_we && reg_addr == 2'd1) ? wr : m_mask;
      n_edge = (reg_we && reg_addr == 2'd2) ? wr : m_edge;
    end
    @(posedge clk);
    m_pend = n_pend; m_mask = n_mask; m_edge = n_edge; m_prev = n_prev;
    m_state = n_state; m_id = n_id; m_rq = n_rq; m_req = (n_state == 1);
    #1;
    chk("model_req",  32'(irq_req), 32'(m_req));
    chk("model_id",   32'(irq_id),  32'(m_id));
    chk("model_regq", reg_q,        m_rq);
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    reg_addr = a; reg_we = 1'b1; reg_d = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
  endtask

  task automatic wait_req(input string nm, input int budget);
    int n = 0;
    while (!irq_req && n < budget) begin tick(); n++; end
    total++;
    if (!irq_req) begin
      bad++;
      $display("FAIL %s: irq_req=0 after %0d cycles, expected 1", nm, n);
    end
  endtask

  typedef struct {
    logic [7:0]  src;
    logic        ack, eoi;
    logic [1:0]  addr;
    logic [31:0] exp_rq;
    logic        exp_req;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    reset = 1'b1; src_in = '0; irq_ack = 0; irq_eoi = 0;
    reg_addr = 2'd0; reg_we = 0; reg_d = '0;
    m_syncq = {};
    for (int k = 0; k < SL; k++) m_syncq.push_back(8'h00);

    // Vector table for a single edge request through ack and eoi
    for (int k = 0; k < SL; k++) tbl.push_back('{8'h20, 0, 0, 2'd0, 32'h0, 0, 3'd0});
    tbl.push_back('{8'h20, 0, 0, 2'd0, 32'h0000_0000, 0, 3'd0});
    tbl.push_back('{8'h20, 0, 0, 2'd0, 32'h0000_0020, 1, 3'd5});
    tbl.push_back('{8'h20, 1, 0, 2'd0, 32'h0000_0020, 0, 3'd5});
    tbl.push_back('{8'h20, 0, 0, 2'd0, 32'h0000_0000, 0, 3'd5});
    tbl.push_back('{8'h20, 0, 1, 2'd3, 32'h8000_0005, 0, 3'd5});
    tbl.push_back('{8'h20, 0, 0, 2'd3, 32'h0000_0005, 0, 3'd5});

    // Reset values
    step(2);
    chk("rst_req", 32'(irq_req), 32'h0);
    chk("rst_id",  32'(irq_id),  32'h0);
    chk("rst_regq", reg_q, 32'h0);
    reset = 1'b0;
    reg_addr = 2'd1; tick(); chk("rst_mask", reg_q, 32'hFF);
    reg_addr = 2'd2; tick(); chk("rst_edge", reg_q, 32'hFF);
    reg_addr = 2'd0; step(3);

    // Test 1: table-driven
    foreach (tbl[i]) begin
      v = tbl[i];
      src_in = v.src; irq_ack = v.ack; irq_eoi = v.eoi; reg_addr = v.addr;
      tick();
      chk($sformatf("t1_req[%0d]", i),  32'(irq_req), 32'(v.exp_req));
      chk($sformatf("t1_id[%0d]", i),   32'(irq_id),  32'(v.exp_id));
      chk($sformatf("t1_regq[%0d]", i), reg_q,        v.exp_rq);
    end
    irq_ack = 0; irq_eoi = 0;

    // Test 2: simultaneous rise, lowest index first, next one after eoi
    src_in = 8'h00; step(2 + SL);
    src_in = 8'h44;
    wait_req("t2_wait", 10);
    chk("t2_id2", 32'(irq_id), 32'd2);
    do_ack();
    chk("t2_req_after_ack", 32'(irq_req), 32'h0);
    do_eoi();
    chk("t2_idle_after_eoi", 32'(irq_req), 32'h0);
    tick();
    chk("t2_req6", 32'(irq_req), 32'h1);
    chk("t2_id6",  32'(irq_id),  32'd6);
    do_ack(); do_eoi();
    src_in = 8'h00; step(2 + SL);

    // Test 3: masked source still latches PENDING
    wr_reg(2'd1, 32'hFE);
    src_in = 8'h01; tick(); src_in = 8'h00;
    step(4 + SL);
    chk("t3_no_req", 32'(irq_req), 32'h0);
    reg_addr = 2'd0; tick();
    chk("t3_pending", reg_q, 32'h01);
    wr_reg(2'd1, 32'hFF);
    chk("t3_req_not_yet", 32'(irq_req), 32'h0);
    tick();
    chk("t3_req0", 32'(irq_req), 32'h1);
    chk("t3_id0",  32'(irq_id),  32'd0);
    do_ack(); do_eoi(); step(1);

    // Test 4: W1C in the same cycle as a new edge keeps the bit set
    src_in = 8'h08; step(SL);
    wr_reg(2'd0, 32'h08);
    reg_addr = 2'd0; tick();
    chk("t4_pending_kept", reg_q, 32'h08);
    wait_req("t4_wait", 10);
    chk("t4_id3", 32'(irq_id), 32'd3);
    do_ack(); do_eoi();
    src_in = 8'h00; step(2 + SL);

    // Test 5: level-mode source re-requests after service
    wr_reg(2'd2, 32'hEF);
    src_in = 8'h10;
    wait_req("t5_wait", 10);
    chk("t5_id4", 32'(irq_id), 32'd4);
    do_ack(); do_eoi();
    chk("t5_gap", 32'(irq_req), 32'h0);
    tick();
    chk("t5_rereq", 32'(irq_req), 32'h1);
    chk("t5_reid4", 32'(irq_id),  32'd4);
    src_in = 8'h00; reg_addr = 2'd0; step(1 + SL);
    tick();
    chk("t5_level_clear", reg_q, 32'h00);
    do_ack(); do_eoi();
    wr_reg(2'd2, 32'hFF); step(1);

    // Test 6: reset while in service
    wr_reg(2'd1, 32'h7F);
    src_in = 8'h02;
    wait_req("t6_wait", 10);
    do_ack();
    reg_addr = 2'd3; tick();
    chk("t6_status_serve", reg_q, 32'h8000_0001);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_req", 32'(irq_req), 32'h0);
    chk("t6_regq", reg_q, 32'h0);
    tick();
    chk("t6_status", reg_q, 32'h0);
    reg_addr = 2'd1; tick();
    chk("t6_mask", reg_q, 32'hFF);
    src_in = 8'h00; step(3 + SL);

    // Randomized phase against the model
    for (int n = 0; n < 1500; n++) begin
      src_in   = src_in ^ 8'($urandom & $urandom & $urandom);
      irq_ack  = irq_req && ($urandom_range(1, 0) == 1);
      irq_eoi  = ($urandom_range(3, 0) == 0);
      reg_addr = 2'($urandom_range(3, 0));
      reg_we   = ($urandom_range(7, 0) == 0);
      reg_d    = $urandom;
      reset    = ($urandom_range(299, 0) == 0);
      tick();
    end
    reset = 0; reg_we = 0; irq_ack = 0; irq_eoi = 0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
